lieat_exu_vpu_vseq08: RTL
=========================

LIEAT_EXU_VPU_VSEQ08 -- requirements
Module: lieat_exu_vpu_vseq08

Interface
REQ-001 The block SHALL have parameter VLMAX, default 8, meaning the number of 8-bit elements per vector operand.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port vseq_i_valid, input, 1, request valid.
REQ-005 The block SHALL have port vseq_i_ready, output, 1, request accepted when valid and ready are both high.
REQ-006 The block SHALL have ports vseq_i_op1 and vseq_i_op2, inputs, 8*VLMAX each, packed elements, element k at bits [8k+7:8k].
REQ-007 The block SHALL have ports vseq_i_vadd, vseq_i_vsub and vseq_i_vrsub, inputs, 1 each, operation select (one-hot).
REQ-008 The block SHALL have port vseq_i_vl, input, 4, requested vector length.
REQ-009 The block SHALL have port vseq_flush, input, 1, cancels any in-flight request.
REQ-010 The block SHALL have port vseq_o_valid, output, 1, result valid.
REQ-011 The block SHALL have port vseq_o_ready, input, 1, consumer ready.
REQ-012 The block SHALL have port vseq_o_data, output, 8*VLMAX, packed result.
REQ-013 The block SHALL have port vseq_o_err, output, 1, illegal op select, qualified by vseq_o_valid.

Function
REQ-014 The block SHALL implement states IDLE, RUN and DONE.
REQ-015 vseq_i_ready SHALL be high only in IDLE and only while vseq_flush is low.
REQ-016 On acceptance the block SHALL latch op1, op2, the op select and the effective VL, clear the result register, and set element index to 0.
REQ-017 Effective VL SHALL be min(vseq_i_vl, VLMAX).
REQ-018 From IDLE the block SHALL go to RUN when effective VL is at least 1 and the op select is exactly one-hot; otherwise it SHALL go directly to DONE.
REQ-019 In RUN the block SHALL process one element per cycle through the single shared 8-bit element unit, writing the unit's result to result element idx and incrementing idx.
REQ-020 The block SHALL go from RUN to DONE in the cycle it writes element VL-1, so that acceptance at cycle T gives vseq_o_valid at T+VL+1.
REQ-021 Element arithmetic SHALL be modulo 2^8: vadd = op1+op2, vsub = op1-op2, vrsub = op2-op1, with no carry or borrow between elements.
REQ-022 Elements idx >= VL (the tail) SHALL be zero in vseq_o_data.
REQ-023 vseq_o_err SHALL be 1 in DONE when the latched op select was not exactly one-hot, and in that case vseq_o_data SHALL be all zero.
REQ-024 vseq_o_valid SHALL be high in DONE while vseq_flush is low; vseq_o_data and vseq_o_err SHALL be held stable until the transfer completes.
REQ-025 From DONE the block SHALL return to IDLE when vseq_o_valid and vseq_o_ready are both high; a new request is accepted no earlier than the following cycle.
REQ-026 vseq_flush high in any state SHALL force IDLE at the next edge, discard the latched request and result, and take precedence over every simultaneous handshake.
REQ-027 Input ports SHALL have no effect outside the accepting cycle.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, idx=0, result=0, vseq_o_valid=0, vseq_o_err=0 and vseq_i_ready=1.
REQ-029 Reset asserted mid-RUN SHALL abandon the request with no output transfer.

Structure
REQ-030 State encodings, VLMAX and the element width of 8 SHALL live in the shared package lieat_exu_vpu_pkg.
REQ-031 The element datapath SHALL be a single instance of lieat_exu_vpu_vunit08, time-shared across elements; the block SHALL contain no other arithmetic.

Verification
REQ-032 op1=0x0807060504030201, op2=0x0101010101010101, vadd, vl=8, o_ready=1 -> o_valid at T+9, data=0x0908070605040302, err=0.
REQ-033 op1 elements all 0x00, op2 elements all 0x01, vsub, vl=3 -> data=0x0000000000FFFFFF, o_valid at T+4.
REQ-034 vrsub, vl=15 -> clamped to 8 and o_valid at T+9; vl=0 -> o_valid at T+1, data=0.
REQ-035 vadd and vsub both high -> o_valid at T+1, err=1, data=0.
REQ-036 flush at T+3 of a vl=8 request -> no o_valid, i_ready=1 at T+4; o_ready held low for 5 cycles in DONE -> data stable, i_ready=0 throughout.
REQ-037 reset asserted mid-RUN -> outputs at reset values immediately, and the next request completes correctly.

Source files
------------

// File: rtl/lieat_exu_vpu_pkg.sv
// Shared definitions for the vector sequencer slice: element width, default
// vector length, sequencer state encoding and the operation-select payload.
package lieat_exu_vpu_pkg;

    localparam int unsigned ELEM_W  = 8;
    localparam int unsigned VLMAX   = 8;
    localparam int unsigned VL_IN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } vseq_state_e;

    // Operation select as presented on the request port (expected one-hot).
    typedef struct packed {
        logic vadd;
        logic vsub;
        logic vrsub;
    } vop_sel_t;

    // True when exactly one operation is selected.
    function automatic logic op_onehot(input vop_sel_t s);
        return (s.vadd & ~s.vsub & ~s.vrsub) |
               (~s.vadd & s.vsub & ~s.vrsub) |
               (~s.vadd & ~s.vsub & s.vrsub);
    endfunction

endpackage

// File: rtl/lieat_exu_vpu_vseq08_vunit.sv
// Single 8-bit element arithmetic unit, shared by the sequencer across elements.
//   a, b  : element operands (op1 element, op2 element)
//   sel   : operation select (vadd: a+b, vsub: a-b, vrsub: b-a), modulo 2^8
//   res_c : combinational element result (zero for an empty select)
module lieat_exu_vpu_vunit08
    import lieat_exu_vpu_pkg::*;
(
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    input  vop_sel_t          sel,
    output logic [ELEM_W-1:0] res_c
);

    always_comb begin
        res_c = '0;
        if (sel.vadd) begin
            res_c = a + b;
        end else if (sel.vsub) begin
            res_c = a - b;
        end else if (sel.vrsub) begin
            res_c = b - a;
        end
    end

endmodule

// File: rtl/lieat_exu_vpu_vseq08.sv
// Vector element sequencer: accepts a vector add/sub/rsub request, runs it one
// element per cycle through a single shared element unit, then presents the
// packed result until the consumer takes it. Flush cancels at any point.
//   clock, reset (async, active-low)
//   vseq_i_valid/vseq_i_ready          : request handshake
//   vseq_i_op1/op2                      : packed operands, element k at [8k+7:8k]
//   vseq_i_vadd/vsub/vrsub, vseq_i_vl   : op select (one-hot) and vector length
//   vseq_flush                          : cancel in-flight request
//   vseq_o_valid/vseq_o_ready           : result handshake
//   vseq_o_data, vseq_o_err             : packed result, illegal-select flag
module lieat_exu_vpu_vseq08 #(
    parameter int unsigned VLMAX = lieat_exu_vpu_pkg::VLMAX
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   vseq_i_valid,
    output logic                                   vseq_i_ready,
    input  logic [lieat_exu_vpu_pkg::ELEM_W*VLMAX-1:0] vseq_i_op1,
    input  logic [lieat_exu_vpu_pkg::ELEM_W*VLMAX-1:0] vseq_i_op2,
    input  logic                                   vseq_i_vadd,
    input  logic                                   vseq_i_vsub,
    input  logic                                   vseq_i_vrsub,
    input  logic [lieat_exu_vpu_pkg::VL_IN_W-1:0]  vseq_i_vl,
    input  logic                                   vseq_flush,
    output logic                                   vseq_o_valid,
    input  logic                                   vseq_o_ready,
    output logic [lieat_exu_vpu_pkg::ELEM_W*VLMAX-1:0] vseq_o_data,
    output logic                                   vseq_o_err
);

    import lieat_exu_vpu_pkg::*;

    localparam int unsigned IDX_W = (VLMAX > 1) ? $clog2(VLMAX) : 1;
    localparam int unsigned VL_W  = $clog2(VLMAX + 1);

    vseq_state_e                     state_q, state_d;
    logic [IDX_W-1:0]                idx_q;
    logic [VL_W-1:0]                 vl_q;
    logic [VLMAX-1:0][ELEM_W-1:0]    op1_q, op2_q, result_q;
    vop_sel_t                        sel_q;
    logic                            err_q;

    vop_sel_t                        sel_in_c;
    logic [VL_W-1:0]                 vl_eff_c;
    logic                            last_c;
    logic                            accept_c;
    logic                            step_c;
    logic [ELEM_W-1:0]               elem_res_c;

    // Request decode: op select payload and VL clamped to VLMAX.
    assign sel_in_c = {vseq_i_vadd, vseq_i_vsub, vseq_i_vrsub};
    assign vl_eff_c = (32'(vseq_i_vl) > VLMAX) ? VL_W'(VLMAX) : VL_W'(vseq_i_vl);
    assign last_c   = (VL_W'(idx_q) + VL_W'(1)) == vl_q;

    lieat_exu_vpu_vunit08 u_vunit (
        .a     (op1_q[idx_q]),
        .b     (op2_q[idx_q]),
        .sel   (sel_q),
        .res_c (elem_res_c)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; flush overrides every handshake.
    always_comb begin
        state_d      = state_q;
        accept_c     = 1'b0;
        step_c       = 1'b0;
        vseq_i_ready = 1'b0;
        vseq_o_valid = 1'b0;
        if (vseq_flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    vseq_i_ready = 1'b1;
                    if (vseq_i_valid) begin
                        accept_c = 1'b1;
                        state_d  = ((vl_eff_c != '0) && op_onehot(sel_in_c)) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    step_c = 1'b1;
                    if (last_c) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    vseq_o_valid = 1'b1;
                    if (vseq_o_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Latched request, element index and result accumulation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_q    <= '0;
            vl_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            sel_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else if (vseq_flush) begin
            idx_q    <= '0;
            vl_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            sel_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else if (accept_c) begin
            idx_q    <= '0;
            vl_q     <= vl_eff_c;
            op1_q    <= vseq_i_op1;
            op2_q    <= vseq_i_op2;
            sel_q    <= sel_in_c;
            err_q    <= ~op_onehot(sel_in_c);
            result_q <= '0;
        end else if (step_c) begin
            result_q[idx_q] <= elem_res_c;
            idx_q           <= idx_q + IDX_W'(1);
        end
    end

    assign vseq_o_data = result_q;
    assign vseq_o_err  = err_q;

endmodule
